// File: rtl/bus_pkg.sv
// Shared definitions for the tri-state bus owner controller.
//   state_t     : controller FSM states (IDLE / GRANT / TURN)
//   DEF_DW      : default bus data width
//   MAX_SRC     : widest supported driver count (width of onehot())
//   onehot()    : index -> one-hot vector of MAX_SRC bits
//   clog2_min1(): $clog2 that never returns less than 1
package bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_TURN
    } state_t;

    localparam int DEF_DW  = 8;
    localparam int MAX_SRC = 8;

    function automatic logic [MAX_SRC-1:0] onehot(input int idx);
        logic [MAX_SRC-1:0] v;
        v = MAX_SRC'(1) << idx;
        return v;
    endfunction

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bus_owner_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req    : per-source request vector
//   ptr    : index where the search starts (highest priority this round)
//   winner : first requesting index at or after ptr, wrapping modulo N_SRC
//   found  : at least one request is set
module rr_arbiter
    import bus_pkg::*;
#(
    parameter  int N_SRC = 2,
    localparam int IW    = clog2_min1(N_SRC)
) (
    input  logic [N_SRC-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [IW-1:0]    winner,
    output logic             found
);

    logic [IW:0] pos;

    // Walk offsets from the far end back towards ptr so the closest
    // requester to ptr is the last (and therefore final) assignment.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        pos    = '0;
        for (int off = N_SRC - 1; off >= 0; off--) begin
            pos = {1'b0, ptr} + (IW+1)'(off);
            if (pos >= (IW+1)'(N_SRC)) begin
                pos = pos - (IW+1)'(N_SRC);
            end
            if (req[pos[IW-1:0]]) begin
                winner = pos[IW-1:0];
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_owner_ctrl.sv
// Owner-side controller for a shared tri-state data bus.
// Arbitrates driver requests round-robin, drives one-hot enables, forces
// TURN_CYC dead cycles between owners and registers the resolved bus.
//   clk      : system clock
//   rst_n    : asynchronous active-low reset
//   req      : per-source level request
//   en       : registered tri-state enables, one-hot or zero
//   bus_in   : resolved bus value
//   rd_data  : captured bus value
//   rd_valid : one-cycle pulse when rd_data/rd_src were updated
//   rd_src   : index of the source that drove rd_data
//   busy     : controller is in GRANT or TURN
module bus_owner_ctrl
    import bus_pkg::*;
#(
    parameter  int N_SRC     = 2,
    parameter  int DW        = DEF_DW,
    parameter  int MAX_BURST = 4,
    parameter  int TURN_CYC  = 1,
    localparam int SW        = clog2_min1(N_SRC),
    localparam int BW        = clog2_min1(MAX_BURST),
    localparam int TW        = clog2_min1(TURN_CYC)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SRC-1:0] req,
    output logic [N_SRC-1:0] en,
    input  logic [DW-1:0]    bus_in,
    output logic [DW-1:0]    rd_data,
    output logic             rd_valid,
    output logic [SW-1:0]    rd_src,
    output logic             busy
);

    state_t           state, state_n;
    logic [SW-1:0]    cur_src, cur_n;
    logic [SW-1:0]    rr_ptr, ptr_n;
    logic [BW-1:0]    beat_cnt, beat_n;
    logic [TW-1:0]    turn_cnt, turn_n;
    logic [N_SRC-1:0] en_n;
    logic [DW-1:0]    rdd_n;
    logic             rdv_n;
    logic [SW-1:0]    rds_n;
    logic [SW-1:0]    winner;
    logic             win_any;
    logic             grant;

    rr_arbiter #(.N_SRC(N_SRC)) u_arb (
        .req    (req),
        .ptr    (rr_ptr),
        .winner (winner),
        .found  (win_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cur_src  <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
            turn_cnt <= '0;
            en       <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_src   <= '0;
        end else begin
            state    <= state_n;
            cur_src  <= cur_n;
            rr_ptr   <= ptr_n;
            beat_cnt <= beat_n;
            turn_cnt <= turn_n;
            en       <= en_n;
            rd_data  <= rdd_n;
            rd_valid <= rdv_n;
            rd_src   <= rds_n;
        end
    end

    always_comb begin
        state_n = state;
        cur_n   = cur_src;
        ptr_n   = rr_ptr;
        beat_n  = beat_cnt;
        turn_n  = turn_cnt;
        en_n    = en;
        rdv_n   = 1'b0;
        rdd_n   = rd_data;
        rds_n   = rd_src;
        grant   = 1'b0;

        case (state)
            ST_IDLE: begin
                en_n  = '0;
                grant = win_any;
            end
            ST_GRANT: begin
                // The current owner drove the bus this whole cycle, so the
                // beat is captured even when its request has just dropped.
                rdv_n = 1'b1;
                rdd_n = bus_in;
                rds_n = cur_src;
                if (!req[cur_src] || beat_cnt == BW'(MAX_BURST - 1)) begin
                    en_n    = '0;
                    state_n = ST_TURN;
                    turn_n  = '0;
                end else begin
                    beat_n = beat_cnt + 1'b1;
                end
            end
            ST_TURN: begin
                en_n = '0;
                if (turn_cnt == TW'(TURN_CYC - 1)) begin
                    if (win_any) begin
                        grant = 1'b1;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else begin
                    turn_n = turn_cnt + 1'b1;
                end
            end
            default: begin
                en_n    = '0;
                state_n = ST_IDLE;
            end
        endcase

        // The pointer moves past the winner at grant time, so an owner that
        // is forcibly released at MAX_BURST queues behind other requesters.
        if (grant) begin
            state_n = ST_GRANT;
            en_n    = N_SRC'(onehot(int'(winner)));
            cur_n   = winner;
            ptr_n   = (winner == SW'(N_SRC - 1)) ? '0 : winner + 1'b1;
            beat_n  = '0;
        end
    end

    assign busy = (state != ST_IDLE);

    a_en_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(en));

    // Enables may only change owner through an all-zero cycle.
    a_en_no_overlap: assert property (@(posedge clk) disable iff (!rst_n)
        (en != '0 && $past(en) != '0) |-> (en == $past(en)));

endmodule

// File: tb/tb_bus_owner_ctrl.sv
module tb_bus_owner_ctrl;
    import bus_pkg::*;

    localparam int NA = 2;
    localparam int NB = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic [NA-1:0] req_a;
    logic [NA-1:0] en_a;
    tri   [7:0]    bus_a;
    logic [7:0]    rdd_a;
    logic          rdv_a;
    logic [0:0]    rds_a;
    logic          busy_a;

    logic [NB-1:0] req_b;
    logic [NB-1:0] en_b;
    tri   [7:0]    bus_b;
    logic [7:0]    rdd_b;
    logic          rdv_b;
    logic [1:0]    rds_b;
    logic          busy_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bus_owner_ctrl #(.N_SRC(NA), .DW(8), .MAX_BURST(4), .TURN_CYC(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req_a), .en(en_a), .bus_in(bus_a),
        .rd_data(rdd_a), .rd_valid(rdv_a), .rd_src(rds_a), .busy(busy_a)
    );

    bus_owner_ctrl #(.N_SRC(NB), .DW(8), .MAX_BURST(1), .TURN_CYC(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req_b), .en(en_b), .bus_in(bus_b),
        .rd_data(rdd_b), .rd_valid(rdv_b), .rd_src(rds_b), .busy(busy_b)
    );

    // External tri-state drivers: source i always presents the value 2+i.
    for (genvar i = 0; i < NA; i++) begin : g_drv_a
        assign bus_a = en_a[i] ? 8'(i + 2) : 8'bz;
    end
    for (genvar i = 0; i < NB; i++) begin : g_drv_b
        assign bus_b = en_b[i] ? 8'(i + 2) : 8'bz;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: who is driving, how many beats used, how many
    // dead cycles still owed, and the next round-robin start position.
    typedef struct {
        int owner;
        int beats;
        int gap;
        int ptr;
        bit vld;
        int src;
    } mdl_t;

    mdl_t ma, mb;

    task automatic mstep(input mdl_t s, input int n, input int maxb, input int turnc,
                         input logic [7:0] r, output mdl_t o);
        o     = s;
        o.vld = (s.owner >= 0);
        if (s.owner >= 0) begin
            o.src   = s.owner;
            o.beats = s.beats + 1;
            if (((r >> s.owner) & 8'd1) == 8'd0 || o.beats == maxb) begin
                o.owner = -1;
                o.gap   = turnc;
            end
        end else begin
            if (s.gap > 0) o.gap = s.gap - 1;
            if (o.gap == 0 && r != 8'd0) begin
                for (int k = n - 1; k >= 0; k--) begin
                    int idx;
                    idx = (s.ptr + k) % n;
                    if (((r >> idx) & 8'd1) != 8'd0) o.owner = idx;
                end
                o.beats = 0;
                o.ptr   = (o.owner + 1) % n;
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        mdl_t ta, tb;
        if (!rst_n) begin
            ma = '{owner: -1, default: 0};
            mb = '{owner: -1, default: 0};
        end else begin
            mstep(ma, NA, 4, 1, 8'(req_a), ta);
            mstep(mb, NB, 1, 3, 8'(req_b), tb);
            ma = ta;
            mb = tb;
        end
    end

    task automatic cmp(input string tag, input mdl_t m, input logic [31:0] en,
                       input logic [31:0] rdv, input logic [31:0] rdd,
                       input logic [31:0] rds, input logic [31:0] bsy);
        chk({tag, "_en"}, en, (m.owner >= 0) ? (32'd1 << m.owner) : 32'd0);
        chk({tag, "_rd_valid"}, rdv, 32'(m.vld));
        chk({tag, "_busy"}, bsy, 32'((m.owner >= 0) || (m.gap > 0)));
        if (m.vld) begin
            chk({tag, "_rd_data"}, rdd, 32'(m.src + 2));
            chk({tag, "_rd_src"}, rds, 32'(m.src));
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("a_onehot0", 32'($onehot0(en_a)), 32'd1);
            chk("b_onehot0", 32'($onehot0(en_b)), 32'd1);
            cmp("a", ma, 32'(en_a), 32'(rdv_a), 32'(rdd_a), 32'(rds_a), 32'(busy_a));
            cmp("b", mb, 32'(en_b), 32'(rdv_b), 32'(rdd_b), 32'(rds_b), 32'(busy_b));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_a = '0;
        req_b = '0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_en", 32'({en_b, en_a}), 32'd0);
        chk("rst_rd_valid", 32'({rdv_b, rdv_a}), 32'd0);
        chk("rst_rd_data", 32'({rdd_b, rdd_a}), 32'd0);
        chk("rst_rd_src", 32'({rds_b, rds_a}), 32'd0);
        chk("rst_busy", 32'({busy_b, busy_a}), 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        req_a = '0;
        req_b = '0;

        // Single owner burst with forced release and re-grant.
        do_reset();
        req_a = 2'b01;
        tick();
        chk("t1_en_first", 32'(en_a), 32'h1);
        chk("t1_busy", 32'(busy_a), 32'd1);
        tick();
        chk("t1_beat1_valid", 32'(rdv_a), 32'd1);
        chk("t1_beat1_data", 32'(rdd_a), 32'd2);
        chk("t1_beat1_src", 32'(rds_a), 32'd0);
        repeat (3) tick();
        chk("t1_release_en", 32'(en_a), 32'h0);
        chk("t1_beat4_valid", 32'(rdv_a), 32'd1);
        tick();
        chk("t1_regrant_en", 32'(en_a), 32'h1);
        chk("t1_turn_no_valid", 32'(rdv_a), 32'd0);
        repeat (4) tick();
        req_a = 2'b00;
        repeat (8) tick();
        chk("t1_idle_busy", 32'(busy_a), 32'd0);

        // Two-way contention alternates owners with dead cycles.
        do_reset();
        req_a = 2'b11;
        tick();
        chk("t2_grant0", 32'(en_a), 32'h1);
        repeat (4) tick();
        chk("t2_gap0", 32'(en_a), 32'h0);
        tick();
        chk("t2_grant1", 32'(en_a), 32'h2);
        tick();
        chk("t2_src1_data", 32'(rdd_a), 32'd3);
        chk("t2_src1_src", 32'(rds_a), 32'd1);
        repeat (3) tick();
        chk("t2_gap1", 32'(en_a), 32'h0);
        tick();
        chk("t2_grant0_again", 32'(en_a), 32'h1);
        req_a = 2'b00;
        repeat (8) tick();

        // One-cycle request yields exactly one beat, then back to idle.
        req_a = 2'b10;
        tick();
        chk("t3_grant", 32'(en_a), 32'h2);
        req_a = 2'b00;
        tick();
        chk("t3_valid", 32'(rdv_a), 32'd1);
        chk("t3_data", 32'(rdd_a), 32'd3);
        chk("t3_src", 32'(rds_a), 32'd1);
        chk("t3_en_off", 32'(en_a), 32'h0);
        tick();
        chk("t3_idle_busy", 32'(busy_a), 32'd0);
        chk("t3_no_valid", 32'(rdv_a), 32'd0);
        repeat (2) tick();

        // Asynchronous reset during the second beat of src0.
        do_reset();
        req_a = 2'b01;
        tick();
        tick();
        chk("t4_first_beat", 32'(rdv_a), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("t4_async_en", 32'(en_a), 32'h0);
        chk("t4_async_valid", 32'(rdv_a), 32'd0);
        chk("t4_async_busy", 32'(busy_a), 32'd0);
        req_a = 2'b10;
        #2 rst_n = 1'b1;
        tick();
        chk("t4_grant_src1", 32'(en_a), 32'h2);
        tick();
        chk("t4_src1_beat", 32'(rds_a), 32'd1);
        req_a = 2'b00;
        repeat (6) tick();

        // Request moves from src0 to src1 while the bus is turning around.
        do_reset();
        req_a = 2'b01;
        tick();
        repeat (4) tick();
        chk("t6_release", 32'(en_a), 32'h0);
        req_a = 2'b10;
        tick();
        chk("t6_grant_src1", 32'(en_a), 32'h2);
        chk("t6_no_src0_beat", 32'(rdv_a), 32'd0);
        tick();
        chk("t6_beat_valid", 32'(rdv_a), 32'd1);
        chk("t6_beat_src", 32'(rds_a), 32'd1);
        chk("t6_beat_data", 32'(rdd_a), 32'd3);
        req_a = 2'b00;
        repeat (6) tick();

        // Four sources, single-beat bursts, three dead cycles.
        do_reset();
        req_b = 4'hf;
        tick();
        chk("t5_grant_0", 32'(en_b), 32'h1);
        tick();
        chk("t5_gap_en", 32'(en_b), 32'h0);
        chk("t5_beat_data", 32'(rdd_b), 32'd2);
        for (int g = 1; g <= 4; g++) begin
            repeat (3) tick();
            chk($sformatf("t5_grant_%0d", g), 32'(en_b), 32'd1 << (g % 4));
            tick();
        end
        req_b = '0;
        repeat (8) tick();
        chk("t5_idle_busy", 32'(busy_b), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_owner_ctrl.md
Name: bus_owner_ctrl

Overview:
- Owner-side controller for the shared tri-state data bus.
- Several tri-state driver instances (in/enable/out) share one resolved bus. This block:
  - arbitrates their requests and drives their one-hot enables;
  - inserts dead turnaround cycles between owners so two drivers never overlap;
  - samples the resolved bus into a registered read port.
- Sits between the CPU bus sources and the consuming datapath register.

Parameters:
- N_SRC, 2: number of tri-state drivers on the bus (2..8).
- DW, 8: bus data width.
- MAX_BURST, 4: max consecutive grant cycles per owner before forced release (1..16).
- TURN_CYC, 1: idle cycles with all enables low between owners (1..4; 0 not allowed).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  N_SRC  per-source bus request, level-sensitive, sampled on clk.
- en  out  N_SRC  tri-state enables to drivers; registered; one-hot or zero.
- bus_in  in  DW  resolved shared bus value.
- rd_data  out  DW  captured bus value.
- rd_valid  out  1  one-cycle pulse: rd_data/rd_src updated.
- rd_src  out  $clog2(N_SRC) (min 1)  index of source that drove rd_data.
- busy  out  1  high in GRANT or TURN.

Behaviour:
- Reset (async, immediate):
  - en=0, rd_data=0, rd_valid=0, rd_src=0, busy=0.
  - state=IDLE, rr_ptr=0, beat_cnt=0, turn_cnt=0.
  - Reset mid-grant releases the bus in the same cycle rst_n falls; no rd_valid is produced for the interrupted beat.
- States: IDLE, GRANT, TURN.
- Arbitration (round-robin):
  - Search starts at rr_ptr and wraps modulo N_SRC; first set req bit wins.
  - On grant: cur_src <= winner, rr_ptr <= (winner+1) mod N_SRC.
- IDLE: en=0.
  - If |req at edge k: state<=GRANT, en<=onehot(winner), beat_cnt<=0.
  - Bus is driven during cycle k..k+1.
- GRANT: en[cur_src]=1. At every edge:
  - rd_data<=bus_in, rd_src<=cur_src, rd_valid<=1 (visible next cycle).
  - Exit when req[cur_src]==0 or beat_cnt==MAX_BURST-1: en<=0, state<=TURN, turn_cnt<=0.
  - Otherwise beat_cnt<=beat_cnt+1.
  - Minimum grant is 1 cycle. Latency from req rising to first rd_valid is 2 edges.
  - A beat whose req drop is seen at the same edge is still captured (valid).
- TURN: en=0 for exactly TURN_CYC cycles (turn_cnt counts 0..TURN_CYC-1). At the last turn edge:
  - if |req: arbitrate, go GRANT, en<=onehot(winner);
  - else go IDLE.
- rd_valid is 0 in every cycle not immediately following a GRANT-cycle edge.
- Hard invariant, checked by assertion: en is never multi-hot; en is 0 for ≥TURN_CYC full cycles between different or same owners.
- Forced release at MAX_BURST: rr_ptr has already advanced, so a still-requesting owner waits behind other requesters. If it is the only requester, it is re-granted after TURN.
- req changes during TURN: ignored until the arbitration edge.
- busy = (state!=IDLE).

Decomposition:
- Shared package bus_pkg:
  - state enum (IDLE/GRANT/TURN);
  - default DW;
  - function onehot(idx);
  - function clog2_min1.
- One natural sub-module: rr_arbiter (req, rr_ptr -> winner index, any). Purely combinational, instantiated once. FSM, counters and capture register stay in bus_owner_ctrl.
- Tri-state drivers remain external; the bench instantiates N_SRC of them on one wire.

Test Plan:
- Single owner, burst: src0 data 8'd2, req=2'b01 held 10 cycles.
  - en=01 on cycle 1; rd_valid pulses with rd_data=2, rd_src=0 for 4 beats.
  - en=00 for 1 cycle, then re-grant.
- Contention: src0=2, src1=3, req=2'b11 from reset.
  - Grants alternate 0,1,0,1, each 4 beats, separated by 1-cycle en=00 gaps.
  - rd_data sequence is 2,2,2,2,3,3,3,3,...; en never 2'b11.
- Short request: req[1] pulsed one cycle.
  - Exactly one beat: rd_data=3, rd_src=1.
  - Then TURN, then IDLE with busy=0.
- Reset mid-grant: rst_n low during the second beat of src0.
  - en=00 and rd_valid=0 asynchronously.
  - After release, with req=2'b10, first grant goes to src1 (rr_ptr=0 scan finds src1).
- TURN_CYC=3, MAX_BURST=1, N_SRC=4, req=4'b1111.
  - Grants 0,1,2,3,0, each followed by exactly 3 zero-enable cycles.
- Request changes in TURN: req moves 01 -> 10 inside TURN.
  - Next grant goes to src1; no beat is captured from src0 after the exit.
